// File: rtl/jt7759_adpcm.sv
// jt7759_adpcm: uPD7759-compatible ADPCM decoder.
// One nibble is consumed per cendec pulse through a three-stage pipeline:
// address latch, synchronous step ROM, then accumulator/step-state write.
// On end-of-sample the output fades one LSB per cendec to zero, after which
// dec_done is raised so the controller can hold the decoder in dec_rst.
module jt7759_adpcm #(
  parameter int SW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cendec,
  input  logic                 dec_rst,
  input  logic                 dec_end,
  input  logic [3:0]           dec_din,
  output logic                 dec_done,
  output logic signed [SW-1:0] sound
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    FADE = 2'd2,
    DONE = 2'd3
  } fsm_t;

  localparam logic signed [SW-1:0] SOUND_MAX  = 9'sd255;
  localparam logic signed [SW-1:0] SOUND_MIN  = -9'sd256;
  localparam logic signed [SW-1:0] SOUND_ZERO = 9'sd0;

  fsm_t                 st_r;
  fsm_t                 st_s;

  // step-state (row of the step table) and pipeline registers
  logic [3:0]           state_r;
  logic [7:0]           addr_r;
  logic                 s1_valid_r;
  logic signed [8:0]    step_r;
  logic [2:0]           adj_idx_r;
  logic                 s2_valid_r;

  logic                 take_s;
  logic                 fade_step_s;
  logic                 pipe_busy_s;

  logic signed [SW:0]   sum_s;
  logic signed [SW-1:0] sound_sat_s;
  logic signed [SW-1:0] sound_fade_s;
  logic signed [5:0]    state_sum_s;
  logic [3:0]           state_new_s;

  // Step magnitude table: row = step state, columns 0..7 packed MSB = col 7.
  // Columns 8..15 are the negated copies of columns 0..7.
  function automatic logic signed [8:0] step_rom(input logic [7:0] a);
    logic [63:0] row;
    logic [7:0]  mag;
    case (a[7:4])
      4'd0:    row = {8'd10,  8'd7,   8'd5,   8'd3,  8'd2,  8'd1,  8'd0,  8'd0};
      4'd1:    row = {8'd13,  8'd8,   8'd6,   8'd4,  8'd3,  8'd2,  8'd1,  8'd0};
      4'd2:    row = {8'd15,  8'd10,  8'd7,   8'd5,  8'd4,  8'd2,  8'd1,  8'd0};
      4'd3:    row = {8'd19,  8'd13,  8'd9,   8'd6,  8'd4,  8'd3,  8'd1,  8'd0};
      4'd4:    row = {8'd23,  8'd15,  8'd11,  8'd8,  8'd5,  8'd3,  8'd2,  8'd0};
      4'd5:    row = {8'd29,  8'd19,  8'd14,  8'd10, 8'd7,  8'd4,  8'd2,  8'd0};
      4'd6:    row = {8'd33,  8'd22,  8'd16,  8'd12, 8'd8,  8'd5,  8'd3,  8'd0};
      4'd7:    row = {8'd43,  8'd29,  8'd20,  8'd15, 8'd10, 8'd7,  8'd4,  8'd1};
      4'd8:    row = {8'd53,  8'd35,  8'd25,  8'd18, 8'd13, 8'd8,  8'd4,  8'd1};
      4'd9:    row = {8'd64,  8'd43,  8'd31,  8'd22, 8'd16, 8'd10, 8'd6,  8'd1};
      4'd10:   row = {8'd76,  8'd51,  8'd37,  8'd27, 8'd19, 8'd12, 8'd7,  8'd2};
      4'd11:   row = {8'd96,  8'd64,  8'd46,  8'd34, 8'd24, 8'd16, 8'd9,  8'd2};
      4'd12:   row = {8'd117, 8'd79,  8'd57,  8'd41, 8'd29, 8'd19, 8'd11, 8'd3};
      4'd13:   row = {8'd143, 8'd96,  8'd69,  8'd50, 8'd36, 8'd24, 8'd13, 8'd4};
      4'd14:   row = {8'd175, 8'd118, 8'd85,  8'd62, 8'd44, 8'd29, 8'd16, 8'd4};
      4'd15:   row = {8'd214, 8'd144, 8'd104, 8'd76, 8'd54, 8'd36, 8'd20, 8'd6};
      default: row = 64'd0;
    endcase
    mag = row[{a[2:0], 3'b000} +: 8];
    if (a[3]) begin
      step_rom = 9'sd0 - $signed({1'b0, mag});
    end else begin
      step_rom = $signed({1'b0, mag});
    end
  endfunction

  // Step-state adjustment indexed by the nibble magnitude bits.
  function automatic logic signed [2:0] state_adj(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: state_adj = -3'sd1;
      3'd2, 3'd3: state_adj = 3'sd0;
      3'd4:       state_adj = 3'sd1;
      3'd5, 3'd6: state_adj = 3'sd2;
      3'd7:       state_adj = 3'sd3;
      default:    state_adj = 3'sd0;
    endcase
  endfunction

  assign pipe_busy_s = s1_valid_r | s2_valid_r;

  // Next-state logic: decides nibble acceptance and fade stepping.
  always_comb begin
    st_s        = st_r;
    take_s      = 1'b0;
    fade_step_s = 1'b0;
    if (dec_rst) begin
      st_s = HOLD;
    end else begin
      case (st_r)
        HOLD: begin
          st_s = RUN;
        end
        RUN: begin
          if (cendec && dec_end) begin
            st_s = FADE;
          end else if (cendec) begin
            take_s = 1'b1;
          end else begin
            st_s = RUN;
          end
        end
        FADE: begin
          // an in-flight nibble lands before fading or finishing
          if (pipe_busy_s) begin
            st_s = FADE;
          end else if (sound == SOUND_ZERO) begin
            st_s = DONE;
          end else if (cendec) begin
            fade_step_s = 1'b1;
          end else begin
            st_s = FADE;
          end
        end
        DONE: begin
          if (cendec && !dec_end) begin
            st_s   = RUN;
            take_s = 1'b1;
          end else begin
            st_s = DONE;
          end
        end
        default: begin
          st_s = HOLD;
        end
      endcase
    end
  end

  // Accumulator saturation, fade step and step-state clamp arithmetic.
  always_comb begin
    sum_s = {sound[SW-1], sound} + {{(SW-8){step_r[8]}}, step_r};
    if (sum_s[SW] != sum_s[SW-1]) begin
      sound_sat_s = sum_s[SW] ? SOUND_MIN : SOUND_MAX;
    end else begin
      sound_sat_s = sum_s[SW-1:0];
    end

    if (sound[SW-1]) begin
      sound_fade_s = sound + 9'sd1;
    end else begin
      sound_fade_s = sound - 9'sd1;
    end

    state_sum_s = $signed({2'b00, state_r}) +
                  $signed({{3{state_adj(adj_idx_r)[2]}}, state_adj(adj_idx_r)});
    if (state_sum_s < 6'sd0) begin
      state_new_s = 4'd0;
    end else if (state_sum_s > 6'sd15) begin
      state_new_s = 4'd15;
    end else begin
      state_new_s = state_sum_s[3:0];
    end
  end

  // FSM state register and registered done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r     <= HOLD;
      dec_done <= 1'b1;
    end else begin
      st_r     <= st_s;
      dec_done <= (st_s == HOLD) || (st_s == DONE);
    end
  end

  // Stage 1: latch the ROM address from current step state and nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= 8'd0;
      s1_valid_r <= 1'b0;
    end else if (dec_rst) begin
      addr_r     <= 8'd0;
      s1_valid_r <= 1'b0;
    end else if (take_s) begin
      addr_r     <= {state_r, dec_din};
      s1_valid_r <= 1'b1;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: synchronous step ROM read, carrying the adjust index along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r     <= 9'sd0;
      adj_idx_r  <= 3'd0;
      s2_valid_r <= 1'b0;
    end else if (dec_rst) begin
      step_r     <= 9'sd0;
      adj_idx_r  <= 3'd0;
      s2_valid_r <= 1'b0;
    end else begin
      step_r     <= step_rom(addr_r);
      adj_idx_r  <= addr_r[2:0];
      s2_valid_r <= s1_valid_r;
    end
  end

  // Stage 3: write the sample and step state, or take one fade step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sound   <= SOUND_ZERO;
      state_r <= 4'd0;
    end else if (dec_rst) begin
      sound   <= SOUND_ZERO;
      state_r <= 4'd0;
    end else if (s2_valid_r) begin
      sound   <= sound_sat_s;
      state_r <= state_new_s;
    end else if (fade_step_s) begin
      sound   <= sound_fade_s;
    end else begin
      sound   <= sound;
    end
  end

endmodule

// File: tb/tb_jt7759_adpcm.sv
// Directed self-checking bench for jt7759_adpcm.
module tb_jt7759_adpcm;

  logic              clk = 1'b0;
  logic              rst;
  logic              cendec;
  logic              dec_rst;
  logic              dec_end;
  logic [3:0]        dec_din;
  logic              dec_done;
  logic signed [8:0] sound;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jt7759_adpcm #(.SW(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .cendec   (cendec),
    .dec_rst  (dec_rst),
    .dec_end  (dec_end),
    .dec_din  (dec_din),
    .dec_done (dec_done),
    .sound    (sound)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // one-clk cendec pulse driven between edges; returns after the sampling edge
  task automatic pulse(input logic [3:0] nib, input logic e);
    @(negedge clk);
    cendec  = 1'b1;
    dec_din = nib;
    dec_end = e;
    @(negedge clk);
    cendec  = 1'b0;
    dec_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // decode one nibble and wait until its result has landed
  task automatic decode(input logic [3:0] nib);
    pulse(nib, 1'b0);
    idle(3);
  endtask

  int sat_up[6]   = '{10, 29, 62, 126, 243, 255};
  int sat_down[3] = '{41, -173, -256};
  int prev;

  initial begin
    rst     = 1'b1;
    cendec  = 1'b0;
    dec_rst = 1'b1;
    dec_end = 1'b0;
    dec_din = 4'd0;
    idle(2);
    check("rst_sound", int'(sound), 0);
    check("rst_done", int'(dec_done), 1);
    check("rst_state", int'(dut.state_r), 0);
    rst = 1'b0;

    // hold: cendec pulses are ignored while dec_rst is high
    idle(10);
    pulse(4'd7, 1'b0);
    idle(4);
    check("hold_sound", int'(sound), 0);
    check("hold_done", int'(dec_done), 1);
    check("hold_state", int'(dut.state_r), 0);

    // basic decode with latency checks
    dec_rst = 1'b0;
    idle(2);
    check("run_done", int'(dec_done), 0);
    pulse(4'd4, 1'b0);
    idle(1);
    check("lat4_early", int'(sound), 0);
    idle(1);
    check("dec4_sound", int'(sound), 3);
    check("dec4_state", int'(dut.state_r), 1);
    idle(4);
    pulse(4'd5, 1'b0);
    idle(1);
    check("lat5_early", int'(sound), 3);
    idle(1);
    check("dec5_sound", int'(sound), 9);
    check("dec5_state", int'(dut.state_r), 3);
    idle(4);

    // fade from 9 to 0, one LSB per cendec after entry
    pulse(4'd0, 1'b1);
    idle(3);
    check("fade_entry", int'(sound), 9);
    check("fade_entry_done", int'(dec_done), 0);
    for (int i = 8; i >= 0; i--) begin
      pulse(4'd0, (i > 4) ? 1'b1 : 1'b0);
      check("fade_step", int'(sound), i);
      idle(2);
    end
    check("fade_done", int'(dec_done), 1);
    pulse(4'd3, 1'b1);
    idle(3);
    check("done_sound", int'(sound), 0);
    check("done_done", int'(dec_done), 1);

    // state clamp at the bottom of the table
    dec_rst = 1'b1;
    idle(2);
    check("clr_sound", int'(sound), 0);
    check("clr_state", int'(dut.state_r), 0);
    dec_rst = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      decode(4'd0);
      check("clamp_state", int'(dut.state_r), 0);
      check("clamp_sound", int'(sound), 0);
    end

    // positive saturation
    prev = int'(sound);
    for (int i = 0; i < 40; i++) begin
      decode(4'd7);
      if (i < 6) begin
        check("sat_up_val", int'(sound), sat_up[i]);
      end else begin
        check("sat_up_hold", int'(sound), 255);
      end
      check("sat_up_mono", int'(int'(sound) >= prev), 1);
      prev = int'(sound);
    end
    check("sat_up_state", int'(dut.state_r), 15);

    // negative saturation
    for (int i = 0; i < 80; i++) begin
      decode(4'd15);
      if (i < 3) begin
        check("sat_dn_val", int'(sound), sat_down[i]);
      end else begin
        check("sat_dn_hold", int'(sound), -256);
      end
      check("sat_dn_mono", int'(int'(sound) <= prev), 1);
      prev = int'(sound);
    end

    // dec_rst for one clk right after a cendec flushes the pipeline
    pulse(4'd7, 1'b0);
    dec_rst = 1'b1;
    idle(1);
    dec_rst = 1'b0;
    check("midrst_sound", int'(sound), 0);
    check("midrst_state", int'(dut.state_r), 0);
    check("midrst_done", int'(dec_done), 1);
    idle(3);
    check("midrst_lost", int'(sound), 0);
    check("midrst_lost_state", int'(dut.state_r), 0);
    decode(4'd4);
    check("restart_sound", int'(sound), 3);
    check("restart_state", int'(dut.state_r), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
